jk_excitation_driver: RTL and testbench
=======================================

Name: jk_excitation_driver

Overview:
- Drives an external JK flip-flop so its Q output follows a stream of target bits.
- For each target bit, it computes J/K from the flip-flop's current Q using the excitation table, drives J/K for exactly one clock, and waits for the flip-flop to settle.
- It then reads Q back and reports pass/fail, with a saturating error count.
- Sits between a bit-stream source (valid/ready) and a jk_flipflop instance sharing the same clock; used as the self-checking counterpart of JK flip-flop stimulus.

Parameters:
- CNT_W, 8, width of err_count.
- SETTLE, 1, idle cycles between the drive cycle and the check cycle (legal range 0..15).

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- tgt_valid  input  1  target bit offered.
- tgt_bit  input  1  desired next Q of the external flip-flop.
- tgt_ready  output  1  block can accept a target bit.
- q_in  input  1  Q returned from the external JK flip-flop.
- j_out  output  1  J drive to the flip-flop (registered).
- k_out  output  1  K drive to the flip-flop (registered).
- chk_valid  output  1  one-cycle pulse: check result valid.
- chk_pass  output  1  q_in matched the target; qualified by chk_valid.
- err_count  output  CNT_W  saturating count of failed checks.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Clock and reset:
  - One clock (clk); reset (rst) is synchronous and active-high.
  - Reset values: state=IDLE; j_out=0; k_out=0; tgt_ready=1; chk_valid=0; chk_pass=0; err_count=0; busy=0.
- FSM states: IDLE, DRIVE, SETTLE_W, CHECK.
- IDLE:
  - tgt_ready=1.
  - On tgt_valid&&tgt_ready: latch tgt_bit, sample q_in as q_cur, register j_out/k_out from the excitation table, go to DRIVE.
- Excitation table (q_cur -> tgt : J K):
  - 0 -> 0 : 0 0
  - 0 -> 1 : 1 0
  - 1 -> 0 : 0 1
  - 1 -> 1 : 0 0
- DRIVE:
  - j_out/k_out hold the computed values for exactly this one cycle; tgt_ready=0.
  - The flip-flop captures J/K on the posedge that ends DRIVE.
  - Next state: SETTLE_W if SETTLE>0, else CHECK.
  - j_out/k_out return to 0/0 (hold) on leaving DRIVE.
- SETTLE_W:
  - Counts SETTLE cycles with j_out=k_out=0, then goes to CHECK.
- CHECK:
  - Compares q_in to the latched target.
  - Registers chk_valid=1 and chk_pass=(q_in==target), visible in the cycle after CHECK.
  - If mismatch, err_count increments, saturating at 2^CNT_W-1 (no wrap).
  - Returns to IDLE.
- Latency:
  - Handshake to j_out/k_out valid: 1 cycle.
  - Handshake to chk_valid: 3+SETTLE cycles.
  - Throughput: one target per 4+SETTLE cycles; tgt_ready=0 while busy.
- chk_valid is a single-cycle pulse; chk_pass holds its last value between pulses.
- tgt_valid is ignored while tgt_ready=0; tgt_bit is captured only at handshake.
- rst asserted in any state: next cycle is IDLE with all reset values.
  - Any in-flight check is discarded: no chk_valid, no err_count update.
  - j_out/k_out forced to 0 in the same edge.
- err_count at max plus a mismatch: stays at max; chk_valid=1, chk_pass=0 still reported.

Optional Feature:
- Macro: JK_TOGGLE_EXCITE_EN.
- Defined: state changes use toggle excitation.
  - 0->1 and 1->0 both drive J=1,K=1.
  - Hold cases are unchanged (0/0).
  - This exercises the flip-flop's toggle path.
- Undefined: the set/reset table above is used (0->1 is 1/0, 1->0 is 0/1).
- Timing, handshake and checking are identical in both builds.

Test Plan:
- Reset then idle:
  - Stimulus: rst=1 for 2 cycles, release.
  - Required: j_out=k_out=0, tgt_ready=1, busy=0, err_count=0, chk_valid never pulses.
- Excitation sweep:
  - Stimulus: SETTLE=1, real jk_flipflop attached, start with q=0, send targets 1,1,0,0.
  - Required J/K in the DRIVE cycles: 1/0, 0/0, 0/1, 0/0.
  - Required: four chk_valid pulses, all chk_pass=1, err_count=0.
  - Each chk_valid arrives 4 cycles after its handshake.
- Fault detection:
  - Stimulus: q_in tied to 0, send targets 1,1,1.
  - Required: three chk_pass=0 results; err_count=3.
- Saturation:
  - Stimulus: CNT_W=2, q_in tied to 1, send six targets of 0.
  - Required: err_count goes 1,2,3,3,3,3; each target still produces chk_valid.
- Backpressure and mid-op reset:
  - Stimulus: hold tgt_valid=1 continuously.
  - Required: handshakes spaced 4+SETTLE cycles apart.
  - Stimulus: assert rst during SETTLE_W.
  - Required: no chk_valid for that target, err_count unchanged, IDLE next cycle.
- JK_TOGGLE_EXCITE_EN build:
  - Stimulus: q=0, send targets 1,0.
  - Required J/K in the DRIVE cycles: 1/1, 1/1; both checks pass.

Source files
------------

// File: rtl/jk_excitation_driver.sv
// Drives J/K of an external JK flip-flop so its Q follows a target bit stream, then reads Q back and scores it.
// Optional build macro JK_TOGGLE_EXCITE_EN: state changes are driven with J=K=1 (toggle) instead of set/reset.
module jk_excitation_driver #(
   parameter int CNT_W  = 8,
   parameter int SETTLE = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tgt_valid,
   input  logic             tgt_bit,
   output logic             tgt_ready,
   input  logic             q_in,
   output logic             j_out,
   output logic             k_out,
   output logic             chk_valid,
   output logic             chk_pass,
   output logic [CNT_W-1:0] err_count,
   output logic             busy
);

   typedef enum logic [1:0] {IDLE, DRIVE, SETTLE_W, CHECK} state_t;

   localparam logic [3:0]       LP_SETTLE_LAST = (SETTLE > 0) ? 4'(SETTLE - 1) : 4'd0;
   localparam logic [CNT_W-1:0] LP_ERR_MAX     = '1;

   state_t     r_state;
   logic       r_tgt;
   logic [3:0] r_settle_cnt;
   logic [1:0] w_jk;
   logic       w_take;

   // Returns {J, K} that moves a flip-flop holding q to target t on the next edge.
   function automatic logic [1:0] f_excite(input logic q, input logic t);
`ifdef JK_TOGGLE_EXCITE_EN
      f_excite = (q != t) ? 2'b11 : 2'b00;
`else
      f_excite = {~q & t, q & ~t};
`endif
   endfunction

   assign w_jk   = f_excite(q_in, tgt_bit);
   assign w_take = tgt_valid && tgt_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= IDLE;
         r_tgt        <= 1'b0;
         r_settle_cnt <= 4'd0;
         j_out        <= 1'b0;
         k_out        <= 1'b0;
         tgt_ready    <= 1'b1;
         chk_valid    <= 1'b0;
         chk_pass     <= 1'b0;
         err_count    <= '0;
         busy         <= 1'b0;
      end else begin
         chk_valid <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_take) begin
                  r_tgt     <= tgt_bit;
                  j_out     <= w_jk[1];
                  k_out     <= w_jk[0];
                  tgt_ready <= 1'b0;
                  busy      <= 1'b1;
                  r_state   <= DRIVE;
               end else begin
                  tgt_ready <= 1'b1;
               end
            end
            DRIVE: begin
               j_out <= 1'b0;
               k_out <= 1'b0;
               if (SETTLE > 0) begin
                  r_settle_cnt <= LP_SETTLE_LAST;
                  r_state      <= SETTLE_W;
               end else begin
                  r_state <= CHECK;
               end
            end
            SETTLE_W: begin
               if (r_settle_cnt == 4'd0) r_state <= CHECK;
               else r_settle_cnt <= r_settle_cnt - 4'd1;
            end
            CHECK: begin
               chk_valid <= 1'b1;
               chk_pass  <= (q_in == r_tgt);
               if ((q_in != r_tgt) && (err_count != LP_ERR_MAX)) err_count <= err_count + 1'b1;
               // tgt_ready rises one IDLE cycle later, giving the 4+SETTLE cadence
               busy    <= 1'b0;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_jk_excitation_driver.sv
// Directed bench for jk_excitation_driver with a behavioural JK flip-flop on q_in.
module tb_jk_excitation_driver;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       tgt_valid = 1'b0;
   logic       tgt_bit = 1'b0;
   logic       tgt_ready, j_out, k_out, chk_valid, chk_pass, busy;
   logic [7:0] err_count;
   logic       q_in, ff_q;
   logic [1:0] q_mode = 2'd0;   // 0: flip-flop, 1: tied 0, 2: tied 1
   logic       q_one = 1'b1;
   logic       s_ready, s_j, s_k, s_valid, s_pass, s_busy;
   logic [1:0] s_err;
   int         n_chk = 0;
   int         n_pass = 0;

   always #5 clk = ~clk;

   always_ff @(posedge clk) begin
      if (rst) ff_q <= 1'b0;
      else case ({j_out, k_out})
         2'b10: ff_q <= 1'b1;
         2'b01: ff_q <= 1'b0;
         2'b11: ff_q <= ~ff_q;
         default: ff_q <= ff_q;
      endcase
   end

   assign q_in = (q_mode == 2'd0) ? ff_q : (q_mode == 2'd2);

   jk_excitation_driver #(.CNT_W(8), .SETTLE(1)) dut (
      .clk(clk), .rst(rst), .tgt_valid(tgt_valid), .tgt_bit(tgt_bit), .tgt_ready(tgt_ready),
      .q_in(q_in), .j_out(j_out), .k_out(k_out), .chk_valid(chk_valid), .chk_pass(chk_pass),
      .err_count(err_count), .busy(busy));

   jk_excitation_driver #(.CNT_W(2), .SETTLE(1)) dut_sat (
      .clk(clk), .rst(rst), .tgt_valid(tgt_valid), .tgt_bit(tgt_bit), .tgt_ready(s_ready),
      .q_in(q_one), .j_out(s_j), .k_out(s_k), .chk_valid(s_valid), .chk_pass(s_pass),
      .err_count(s_err), .busy(s_busy));

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   // One target through the whole handshake/drive/settle/check sequence.
   task automatic send(input logic b, input logic ej, input logic ek, input logic ep,
                       input int eerr, input logic chk_sat, input int eerr_sat);
      int n;
      n = 0;
      while (!tgt_ready && n < 20) begin
         tick();
         n++;
      end
      chk_eq("ready_before", tgt_ready, 1);
      tgt_valid = 1'b1;
      tgt_bit   = b;
      tick();
      tgt_valid = 1'b0;
      tgt_bit   = ~b;
      chk_eq("j_drive", j_out, ej);
      chk_eq("k_drive", k_out, ek);
      chk_eq("busy_drive", busy, 1);
      chk_eq("ready_drive", tgt_ready, 0);
      n = 1;
      while (!chk_valid && n < 12) begin
         tick();
         n++;
      end
      chk_eq("chk_latency", n, 4);
      chk_eq("chk_pass", chk_pass, ep);
      chk_eq("err_count", err_count, eerr);
      chk_eq("jk_idle", {j_out, k_out}, 0);
      if (chk_sat) begin
         chk_eq("sat_valid", s_valid, 1);
         chk_eq("sat_pass", s_pass, 0);
         chk_eq("sat_err", s_err, eerr_sat);
      end
      tick();
      chk_eq("pulse_end", chk_valid, 0);
      chk_eq("pass_hold", chk_pass, ep);
   endtask

   initial begin
      int hs[$];
      int n;
      logic [1:0] jk_up, jk_dn;
`ifdef JK_TOGGLE_EXCITE_EN
      jk_up = 2'b11;
      jk_dn = 2'b11;
`else
      jk_up = 2'b10;
      jk_dn = 2'b01;
`endif

      // reset then idle
      do_reset();
      chk_eq("rst_j", j_out, 0);
      chk_eq("rst_k", k_out, 0);
      chk_eq("rst_ready", tgt_ready, 1);
      chk_eq("rst_busy", busy, 0);
      chk_eq("rst_err", err_count, 0);
      for (int i = 0; i < 5; i++) begin
         chk_eq("rst_no_pulse", chk_valid, 0);
         tick();
      end

      // excitation sweep against the flip-flop model, q starts at 0
      q_mode = 2'd0;
      send(1'b1, jk_up[1], jk_up[0], 1'b1, 0, 1'b0, 0);
      send(1'b1, 1'b0, 1'b0, 1'b1, 0, 1'b0, 0);
      send(1'b0, jk_dn[1], jk_dn[0], 1'b1, 0, 1'b0, 0);
      send(1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0, 0);

      // fault detection with q stuck at 0
      q_mode = 2'd1;
      send(1'b1, jk_up[1], jk_up[0], 1'b0, 1, 1'b0, 0);
      send(1'b1, jk_up[1], jk_up[0], 1'b0, 2, 1'b0, 0);
      send(1'b1, jk_up[1], jk_up[0], 1'b0, 3, 1'b0, 0);

      // saturation: both instances see q stuck at 1 and six targets of 0
      do_reset();
      q_mode = 2'd2;
      send(1'b0, jk_dn[1], jk_dn[0], 1'b0, 1, 1'b1, 1);
      send(1'b0, jk_dn[1], jk_dn[0], 1'b0, 2, 1'b1, 2);
      send(1'b0, jk_dn[1], jk_dn[0], 1'b0, 3, 1'b1, 3);
      send(1'b0, jk_dn[1], jk_dn[0], 1'b0, 4, 1'b1, 3);
      send(1'b0, jk_dn[1], jk_dn[0], 1'b0, 5, 1'b1, 3);
      send(1'b0, jk_dn[1], jk_dn[0], 1'b0, 6, 1'b1, 3);

      // backpressure: tgt_valid held high
      do_reset();
      q_mode    = 2'd0;
      tgt_valid = 1'b1;
      tgt_bit   = 1'b1;
      for (int c = 0; c < 22; c++) begin
         if (tgt_valid && tgt_ready) hs.push_back(c);
         chk_eq("ready_vs_busy", tgt_ready && busy, 0);
         tick();
      end
      tgt_valid = 1'b0;
      chk_eq("bp_hs_count", hs.size(), 5);
      for (int i = 1; i < hs.size(); i++) chk_eq("bp_spacing", hs[i] - hs[i-1], 5);

      // reset in SETTLE_W discards the in-flight check
      do_reset();
      q_mode = 2'd1;
      tgt_valid = 1'b1;
      tgt_bit   = 1'b1;
      tick();
      tgt_valid = 1'b0;
      tick();
      chk_eq("mid_busy", busy, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk_eq("mid_busy_clr", busy, 0);
      chk_eq("mid_jk", {j_out, k_out}, 0);
      chk_eq("mid_ready", tgt_ready, 1);
      chk_eq("mid_err", err_count, 0);
      n = 0;
      for (int i = 0; i < 6; i++) begin
         if (chk_valid) n++;
         tick();
      end
      chk_eq("mid_no_pulse", n, 0);
      chk_eq("mid_err_after", err_count, 0);
      chk_eq("mid_idle", busy, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

endmodule
